// File: rtl/lm32_icache_refill_ctrl_pkg.sv
// Shared definitions for the LM32 instruction-cache refill controller.
// Holds the FSM state encoding, Wishbone cycle/burst type constants and the word-address width.
// Also provides a width-clamp helper used to size the optional watchdog counter.
package lm32_icache_refill_ctrl_pkg;

    localparam int WORD_ADR_W = 30;            // LM32 word address covers byte address bits [31:2]

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_END    = 3'b111;
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [3:0] SEL_ALL    = 4'b1111;

    function automatic int clamp_width(input int w, input int lo, input int hi);
        if (w < lo) return lo;
        if (w > hi) return hi;
        return w;
    endfunction

endpackage

// File: rtl/lm32_irefill_watchdog.sv
// Per-beat watchdog: counts stalled strobe cycles and fires when the limit is reached.
// Latency: o_timeout is combinational once the count equals timeout_cycles.
// Backpressure: none; clears on every completed beat, on timeout, or when no strobe is active.
// Ports: clk_i/rst_i clock and async active-low reset; i_active strobe outstanding;
//        i_clear beat completed by the slave; o_timeout treat this cycle as an errored beat.
module lm32_irefill_watchdog
    import lm32_icache_refill_ctrl_pkg::*;
#(
    parameter int timeout_cycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_active,
    input  logic i_clear,
    output logic o_timeout
);

    localparam int CNT_W = clamp_width($clog2(timeout_cycles + 1), 8, 16);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(timeout_cycles);

    logic [CNT_W-1:0] r_cnt;

    // r_cnt equals the number of stalled cycles already spent on this beat.
    assign o_timeout = i_active & ~i_clear & (r_cnt == LIMIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (!i_active || i_clear || o_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lm32_icache_refill_ctrl.sv
// Wishbone B3 instruction-bus master that refills one icache line as an incrementing burst from word 0.
// Latency: first address one cycle after refill_request; refill_ready is combinational with ack/err.
// Backpressure: slave stalls (no ack/err, or rty) hold address and strobe; errored beats still advance.
// Ports: clk_i/rst_i clock and async active-low reset; refill_request/refill_address from the cache;
//        refill_ready/refill_data/bus_error_f back to cache and fetch; i_* Wishbone instruction port.
// Optional: define LM32_IREFILL_TIMEOUT_EN to turn a beat stalled for timeout_cycles into an error beat.
module lm32_icache_refill_ctrl
    import lm32_icache_refill_ctrl_pkg::*;
#(
    parameter int bytes_per_line = 16,
    parameter int timeout_cycles = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  refill_request,
    input  logic [WORD_ADR_W-1:0] refill_address,
    output logic                  refill_ready,
    output logic [31:0]           refill_data,
    output logic                  bus_error_f,
    output logic                  i_cyc_o,
    output logic                  i_stb_o,
    output logic [31:0]           i_adr_o,
    output logic [2:0]            i_cti_o,
    output logic [1:0]            i_bte_o,
    output logic [3:0]            i_sel_o,
    output logic                  i_we_o,
    input  logic [31:0]           i_dat_i,
    input  logic                  i_ack_i,
    input  logic                  i_err_i,
    input  logic                  i_rty_i
);

    localparam int WPL   = bytes_per_line / 4;
    localparam int WB    = $clog2(WPL);
    localparam int CNT_W = (WB == 0) ? 1 : WB;
    localparam logic [WORD_ADR_W-1:0] OFFSET_MASK = WORD_ADR_W'(WPL - 1);
    localparam logic [CNT_W-1:0]      LAST_WORD   = CNT_W'(WPL - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_cyc, w_cyc_nxt;
    logic                  r_stb, w_stb_nxt;
    logic [WORD_ADR_W-1:0] r_line_base, w_line_base_nxt;
    logic [CNT_W-1:0]      r_word_cnt, w_word_cnt_nxt;
    logic                  r_bus_error_f, w_bus_error_nxt;

    logic w_active;
    logic w_timeout;
    logic w_beat_done;
    logic w_beat_err;
    logic w_last;
    logic w_unused;

    // Retry needs no handling of its own: without ack/err no beat completes, so the
    // address and strobe are simply held and the slave re-presents the beat.
    assign w_unused = &{1'b0, i_rty_i, (timeout_cycles > 0)};

    assign w_active    = (r_state == BURST) & r_stb;
    assign w_beat_done = w_active & (i_ack_i | i_err_i | w_timeout);
    assign w_beat_err  = w_active & (i_err_i | w_timeout);   // err wins over a simultaneous ack
    assign w_last      = (r_word_cnt == LAST_WORD);

`ifdef LM32_IREFILL_TIMEOUT_EN
    lm32_irefill_watchdog #(
        .timeout_cycles(timeout_cycles)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_active (w_active),
        .i_clear  (i_ack_i | i_err_i),
        .o_timeout(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    assign refill_ready = w_beat_done;
    assign refill_data  = (w_beat_done && !w_beat_err) ? i_dat_i : 32'h0;
    assign bus_error_f  = r_bus_error_f;

    assign i_cyc_o = r_cyc;
    assign i_stb_o = r_stb;
    // Line base has its offset bits cleared, so OR-ing the word counter forms the beat address.
    assign i_adr_o = {r_line_base | WORD_ADR_W'(r_word_cnt), 2'b00};
    assign i_cti_o = (r_cyc && !w_last) ? CTI_INCR : CTI_END;
    assign i_bte_o = BTE_LINEAR;
    assign i_sel_o = SEL_ALL;
    assign i_we_o  = 1'b0;

    always_comb begin
        w_state_nxt     = r_state;
        w_cyc_nxt       = r_cyc;
        w_stb_nxt       = r_stb;
        w_line_base_nxt = r_line_base;
        w_word_cnt_nxt  = r_word_cnt;
        w_bus_error_nxt = r_bus_error_f;
        case (r_state)
            IDLE: begin
                if (refill_request) begin
                    w_state_nxt     = BURST;
                    w_cyc_nxt       = 1'b1;
                    w_stb_nxt       = 1'b1;
                    w_line_base_nxt = refill_address & ~OFFSET_MASK;
                    w_word_cnt_nxt  = '0;
                    w_bus_error_nxt = 1'b0;
                end
            end
            BURST: begin
                if (w_beat_done) begin
                    w_word_cnt_nxt = w_last ? '0 : r_word_cnt + CNT_W'(1);
                    if (w_beat_err) begin
                        w_bus_error_nxt = 1'b1;
                    end
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_cyc_nxt   = 1'b0;
                        w_stb_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_line_base   <= '0;
            r_word_cnt    <= '0;
            r_bus_error_f <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cyc         <= w_cyc_nxt;
            r_stb         <= w_stb_nxt;
            r_line_base   <= w_line_base_nxt;
            r_word_cnt    <= w_word_cnt_nxt;
            r_bus_error_f <= w_bus_error_nxt;
        end
    end

endmodule

// File: tb/tb_lm32_icache_refill_ctrl.sv
// Directed bench for the icache refill controller: 16-byte lines (4 beats per refill).
// Inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_lm32_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refill_request;
    logic [29:0] refill_address;
    logic        refill_ready;
    logic [31:0] refill_data;
    logic        bus_error_f;
    logic        i_cyc_o, i_stb_o, i_we_o;
    logic [31:0] i_adr_o;
    logic [2:0]  i_cti_o;
    logic [1:0]  i_bte_o;
    logic [3:0]  i_sel_o;
    logic [31:0] i_dat_i;
    logic        i_ack_i, i_err_i, i_rty_i;

    int n_checks = 0;
    int n_err    = 0;
    int n_strb   = 0;

    always #5 clk = ~clk;

    lm32_icache_refill_ctrl #(
        .bytes_per_line(16),
        .timeout_cycles(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .refill_request(refill_request),
        .refill_address(refill_address),
        .refill_ready  (refill_ready),
        .refill_data   (refill_data),
        .bus_error_f   (bus_error_f),
        .i_cyc_o       (i_cyc_o),
        .i_stb_o       (i_stb_o),
        .i_adr_o       (i_adr_o),
        .i_cti_o       (i_cti_o),
        .i_bte_o       (i_bte_o),
        .i_sel_o       (i_sel_o),
        .i_we_o        (i_we_o),
        .i_dat_i       (i_dat_i),
        .i_ack_i       (i_ack_i),
        .i_err_i       (i_err_i),
        .i_rty_i       (i_rty_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and confirm the bus is still idle in the request cycle.
    task automatic start(input string tag, input logic [29:0] adr);
        @(negedge clk);
        refill_request = 1'b1;
        refill_address = adr;
        i_ack_i = 1'b0; i_err_i = 1'b0; i_rty_i = 1'b0;
        #1;
        chk({tag, "_req_cyc"}, 32'(i_cyc_o), 32'h0);
        chk({tag, "_req_rdy"}, 32'(refill_ready), 32'h0);
        n_strb = 0;
    endtask

    // One beat: `stalls` cycles without ack (rty raised in stall `rty_at`), then ack (plus err if use_err).
    task automatic beat(input string tag, input int stalls, input int rty_at, input bit use_err,
                        input logic [31:0] exp_adr, input logic [2:0] exp_cti,
                        input logic [31:0] dat, input logic exp_berr);
        for (int s = 0; s < stalls; s++) begin
            @(negedge clk);
            i_ack_i = 1'b0; i_err_i = 1'b0; i_rty_i = (s == rty_at);
            #1;
            chk({tag, "_stall_adr"}, i_adr_o, exp_adr);
            chk({tag, "_stall_stb"}, 32'(i_stb_o), 32'h1);
            chk({tag, "_stall_rdy"}, 32'(refill_ready), 32'h0);
            n_strb += int'(refill_ready);
        end
        @(negedge clk);
        i_rty_i = 1'b0; i_ack_i = 1'b1; i_err_i = use_err; i_dat_i = dat;
        #1;
        chk({tag, "_adr"}, i_adr_o, exp_adr);
        chk({tag, "_cti"}, 32'(i_cti_o), 32'(exp_cti));
        chk({tag, "_rdy"}, 32'(refill_ready), 32'h1);
        chk({tag, "_dat"}, refill_data, use_err ? 32'h0 : dat);
        chk({tag, "_berr"}, 32'(bus_error_f), 32'(exp_berr));
        n_strb += int'(refill_ready);
    endtask

    task automatic idle(input string tag, input logic exp_berr);
        @(negedge clk);
        refill_request = 1'b0;
        i_ack_i = 1'b0; i_err_i = 1'b0; i_rty_i = 1'b0;
        #1;
        chk({tag, "_cyc"}, 32'(i_cyc_o), 32'h0);
        chk({tag, "_stb"}, 32'(i_stb_o), 32'h0);
        chk({tag, "_rdy"}, 32'(refill_ready), 32'h0);
        chk({tag, "_berr"}, 32'(bus_error_f), 32'(exp_berr));
    endtask

    localparam logic [2:0] INC = 3'b010;
    localparam logic [2:0] END = 3'b111;

    initial begin
        rst_n = 1'b0;
        refill_request = 1'b0; refill_address = '0;
        i_dat_i = '0; i_ack_i = 1'b0; i_err_i = 1'b0; i_rty_i = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_cyc", 32'(i_cyc_o), 32'h0);
        chk("rst_stb", 32'(i_stb_o), 32'h0);
        chk("rst_adr", i_adr_o, 32'h0);
        chk("rst_cti", 32'(i_cti_o), 32'h7);
        chk("rst_rdy", 32'(refill_ready), 32'h0);
        chk("rst_dat", refill_data, 32'h0);
        chk("rst_berr", 32'(bus_error_f), 32'h0);
        chk("rst_bte", 32'(i_bte_o), 32'h0);
        chk("rst_sel", 32'(i_sel_o), 32'hF);
        chk("rst_we", 32'(i_we_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait fill of the line holding word 0x47 (byte 0x11C): fetched from 0x110 upward
        start("t1", 30'h0000_0047);
        beat("t1_b0", 0, -1, 1'b0, 32'h110, INC, 32'hA000_0000, 1'b0);
        beat("t1_b1", 0, -1, 1'b0, 32'h114, INC, 32'hA000_0001, 1'b0);
        beat("t1_b2", 0, -1, 1'b0, 32'h118, INC, 32'hA000_0002, 1'b0);
        beat("t1_b3", 0, -1, 1'b0, 32'h11C, END, 32'hA000_0003, 1'b0);
        idle("t1_end", 1'b0);
        chk("t1_strobes", 32'(n_strb), 32'd4);

        // Wait states with one retry cycle on the second beat (address 0x314 held 4 cycles)
        start("t2", 30'h0000_00C5);
        beat("t2_b0", 0, -1, 1'b0, 32'h310, INC, 32'hB000_0010, 1'b0);
        beat("t2_b1", 3,  1, 1'b0, 32'h314, INC, 32'hB000_0011, 1'b0);
        beat("t2_b2", 0, -1, 1'b0, 32'h318, INC, 32'hB000_0012, 1'b0);
        beat("t2_b3", 0, -1, 1'b0, 32'h31C, END, 32'hB000_0013, 1'b0);
        idle("t2_end", 1'b0);
        chk("t2_strobes", 32'(n_strb), 32'd4);

        // Error on the third beat (ack and err together: err wins), burst still completes
        start("t3", 30'h0000_0002);
        beat("t3_b0", 0, -1, 1'b0, 32'h000, INC, 32'hC000_0020, 1'b0);
        beat("t3_b1", 0, -1, 1'b0, 32'h004, INC, 32'hC000_0021, 1'b0);
        beat("t3_b2", 0, -1, 1'b1, 32'h008, INC, 32'hC000_0022, 1'b0);
        beat("t3_b3", 0, -1, 1'b0, 32'h00C, END, 32'hC000_0023, 1'b1);
        chk("t3_strobes", 32'(n_strb), 32'd4);

        // Back-to-back miss at 0x200 straight after the errored burst; flag clears on the new burst
        @(negedge clk);
        refill_request = 1'b1; refill_address = 30'h0000_0080;
        i_ack_i = 1'b0; i_err_i = 1'b0;
        #1;
        chk("t4_gap_cyc", 32'(i_cyc_o), 32'h0);
        chk("t4_gap_berr", 32'(bus_error_f), 32'h1);
        n_strb = 0;
        beat("t4_b0", 0, -1, 1'b0, 32'h200, INC, 32'hD000_0030, 1'b0);
        beat("t4_b1", 0, -1, 1'b0, 32'h204, INC, 32'hD000_0031, 1'b0);
        beat("t4_b2", 0, -1, 1'b0, 32'h208, INC, 32'hD000_0032, 1'b0);
        beat("t4_b3", 0, -1, 1'b0, 32'h20C, END, 32'hD000_0033, 1'b0);
        idle("t4_end", 1'b0);
        chk("t4_strobes", 32'(n_strb), 32'd4);

        // Asynchronous reset mid-burst, just after beat 0 completed
        start("t5", 30'h0000_0047);
        beat("t5_b0", 0, -1, 1'b0, 32'h110, INC, 32'hE000_0040, 1'b0);
        @(negedge clk);
        i_ack_i = 1'b1; i_dat_i = 32'hE000_0041;
        #1;
        chk("t5_pre_cyc", 32'(i_cyc_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_arst_cyc", 32'(i_cyc_o), 32'h0);
        chk("t5_arst_stb", 32'(i_stb_o), 32'h0);
        chk("t5_arst_adr", i_adr_o, 32'h0);
        chk("t5_arst_cti", 32'(i_cti_o), 32'h7);
        chk("t5_arst_rdy", 32'(refill_ready), 32'h0);
        chk("t5_arst_dat", refill_data, 32'h0);
        @(negedge clk); #1;
        chk("t5_hold_cyc", 32'(i_cyc_o), 32'h0);
        chk("t5_hold_rdy", 32'(refill_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; i_ack_i = 1'b0;
        n_strb = 0;
        beat("t5_r0", 0, -1, 1'b0, 32'h110, INC, 32'hE000_0050, 1'b0);
        beat("t5_r1", 0, -1, 1'b0, 32'h114, INC, 32'hE000_0051, 1'b0);
        beat("t5_r2", 0, -1, 1'b0, 32'h118, INC, 32'hE000_0052, 1'b0);
        beat("t5_r3", 0, -1, 1'b0, 32'h11C, END, 32'hE000_0053, 1'b0);
        idle("t5_end", 1'b0);
        chk("t5_strobes", 32'(n_strb), 32'd4);

`ifdef LM32_IREFILL_TIMEOUT_EN
        // Slave never answers beat 0: 8 stalled cycles, then a forced error beat
        start("t6", 30'h0000_0047);
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            i_ack_i = 1'b0; i_err_i = 1'b0;
            #1;
            chk("t6_stall_rdy", 32'(refill_ready), 32'h0);
            chk("t6_stall_adr", i_adr_o, 32'h110);
        end
        @(negedge clk); #1;
        chk("t6_to_rdy", 32'(refill_ready), 32'h1);
        chk("t6_to_dat", refill_data, 32'h0);
        beat("t6_b1", 0, -1, 1'b0, 32'h114, INC, 32'hF000_0061, 1'b1);
        beat("t6_b2", 0, -1, 1'b0, 32'h118, INC, 32'hF000_0062, 1'b1);
        beat("t6_b3", 0, -1, 1'b0, 32'h11C, END, 32'hF000_0063, 1'b1);
        idle("t6_end", 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
